// File: rtl/awg_sweep_ctrl.sv
// Frequency-sweep sequencer feeding Fre_word to the AWG/DDS core.
// Steps a tuning word start->stop (optionally back down / repeating), holding each word dwell+1 cycles.
module awg_sweep_ctrl #(
  parameter int PHASE_WIDTH = 32,
  parameter int DWELL_WIDTH = 24
) (
  input  logic                   clk_in,
  input  logic                   RST,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   mode_loop,
  input  logic                   mode_bidir,
  input  logic [PHASE_WIDTH-1:0] f_start,
  input  logic [PHASE_WIDTH-1:0] f_stop,
  input  logic [PHASE_WIDTH-1:0] f_step,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [PHASE_WIDTH-1:0] Fre_word,
  output logic                   busy,
  output logic                   step_tick,
  output logic                   sweep_done
);
  localparam int PW = PHASE_WIDTH;
  localparam int DW = DWELL_WIDTH;

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   f_start_l, f_stop_l, f_step_l;
  logic [DW-1:0]   dwell_l, cnt, cnt_nx;
  logic            loop_l, bidir_l;
  logic [PW-1:0]   fre_nx;
  logic            tick_nx, done_nx;

  logic            go, degen, step_due, at_top, at_bot;
  logic [PW:0]     up_sum, dn_diff, turn_dn_diff, turn_up_sum;
  logic [PW-1:0]   up_next, dn_next, turn_dn, turn_up;

  assign go       = start & ~stop & (state == IDLE);
  assign degen    = (f_step == '0) | (f_stop <= f_start);
  assign step_due = (state != IDLE) && (cnt == dwell_l);
  assign at_top   = (Fre_word == f_stop_l);
  assign at_bot   = (Fre_word == f_start_l);

  // All step arithmetic carries one extra bit so wrap-around is seen as overshoot.
  assign up_sum       = {1'b0, Fre_word} + {1'b0, f_step_l};
  assign up_next      = (up_sum > {1'b0, f_stop_l}) ? f_stop_l : up_sum[PW-1:0];
  assign dn_diff      = {1'b0, Fre_word} - {1'b0, f_step_l};
  assign dn_next      = (dn_diff[PW] || dn_diff[PW-1:0] < f_start_l) ? f_start_l : dn_diff[PW-1:0];
  assign turn_dn_diff = {1'b0, f_stop_l} - {1'b0, f_step_l};
  assign turn_dn      = (turn_dn_diff[PW] || turn_dn_diff[PW-1:0] < f_start_l) ?
                        f_start_l : turn_dn_diff[PW-1:0];
  assign turn_up_sum  = {1'b0, f_start_l} + {1'b0, f_step_l};
  assign turn_up      = (turn_up_sum > {1'b0, f_stop_l}) ? f_stop_l : turn_up_sum[PW-1:0];

  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      Fre_word   <= '0;
      busy       <= 1'b0;
      step_tick  <= 1'b0;
      sweep_done <= 1'b0;
      f_start_l  <= '0;
      f_stop_l   <= '0;
      f_step_l   <= '0;
      dwell_l    <= '0;
      loop_l     <= 1'b0;
      bidir_l    <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      Fre_word   <= fre_nx;
      busy       <= (state_nx != IDLE);
      step_tick  <= tick_nx;
      sweep_done <= done_nx;
      if (go) begin
        f_start_l <= f_start;
        f_stop_l  <= f_stop;
        f_step_l  <= f_step;
        dwell_l   <= dwell;
        loop_l    <= mode_loop;
        bidir_l   <= mode_bidir;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (go && !degen) state_nx = UP;
      UP: begin
        if (stop) state_nx = IDLE;
        else if (step_due && at_top) begin
          if (bidir_l)     state_nx = DOWN;
          else if (loop_l) state_nx = UP;
          else             state_nx = IDLE;
        end
      end
      DOWN: begin
        if (stop) state_nx = IDLE;
        else if (step_due && at_bot) state_nx = loop_l ? UP : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Next datapath/pulse values; every output is registered from these.
  always_comb begin
    fre_nx  = Fre_word;
    cnt_nx  = cnt;
    tick_nx = 1'b0;
    done_nx = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          fre_nx  = f_start;
          cnt_nx  = '0;
          done_nx = degen;
        end
      end
      UP: begin
        if (stop) cnt_nx = '0;
        else if (step_due) begin
          cnt_nx = '0;
          if (!at_top) begin
            fre_nx  = up_next;
            tick_nx = 1'b1;
          end else if (bidir_l) begin
            fre_nx  = turn_dn;
            tick_nx = 1'b1;
          end else if (loop_l) begin
            fre_nx  = f_start_l;
            tick_nx = 1'b1;
          end else begin
            done_nx = 1'b1;
          end
        end else cnt_nx = cnt + DW'(1);
      end
      DOWN: begin
        if (stop) cnt_nx = '0;
        else if (step_due) begin
          cnt_nx = '0;
          if (!at_bot) begin
            fre_nx  = dn_next;
            tick_nx = 1'b1;
          end else if (loop_l) begin
            fre_nx  = turn_up;
            tick_nx = 1'b1;
          end else begin
            done_nx = 1'b1;
          end
        end else cnt_nx = cnt + DW'(1);
      end
      default: cnt_nx = '0;
    endcase
  end

endmodule

// File: tb/tb_awg_sweep_ctrl.sv
// Scoreboard bench for awg_sweep_ctrl: expected per-cycle outputs are queued when a sweep
// is launched and compared cycle by cycle on the falling clock edge.
module tb_awg_sweep_ctrl;
  logic        clk_in = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0, stop = 1'b0, mode_loop = 1'b0, mode_bidir = 1'b0;
  logic [31:0] f_start = '0, f_stop = '0, f_step = '0;
  logic [23:0] dwell = '0;
  logic [31:0] Fre_word;
  logic        busy, step_tick, sweep_done;

  typedef struct {
    logic [31:0] fre;
    logic        busy;
    logic        tick;
    logic        done;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   ticks_seen = 0;

  always #5 clk_in = ~clk_in;

  awg_sweep_ctrl dut (
    .clk_in(clk_in), .RST(RST), .start(start), .stop(stop),
    .mode_loop(mode_loop), .mode_bidir(mode_bidir),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .Fre_word(Fre_word), .busy(busy), .step_tick(step_tick), .sweep_done(sweep_done)
  );

  task automatic push(input logic [31:0] fre, input logic b, input logic t, input logic d);
    exp_t e;
    e.fre = fre; e.busy = b; e.tick = t; e.done = d;
    sb.push_back(e);
  endtask

  // One swept word held n cycles; tick only on its first cycle when it is a step.
  task automatic push_hold(input logic [31:0] w, input int n, input logic first_tick);
    for (int i = 0; i < n; i++) push(w, 1'b1, first_tick && (i == 0), 1'b0);
  endtask

  // Called on a negedge; inputs are sampled at the next posedge.
  task automatic do_start(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                          input logic [23:0] dw, input logic lp, input logic bd, input logic also_stop);
    f_start = fs; f_stop = fe; f_step = st; dwell = dw;
    mode_loop = lp; mode_bidir = bd;
    start = 1'b1; stop = also_stop;
    @(negedge clk_in);
    start = 1'b0; stop = 1'b0;
  endtask

  // Drain the scoreboard one cycle per entry; optionally pulse start/stop after entry pulse_at.
  task automatic check_queue(input string name, input int pulse_at, input logic use_stop);
    exp_t e;
    int   i;
    i = 0;
    ticks_seen = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      if ({Fre_word, busy, step_tick, sweep_done} !== {e.fre, e.busy, e.tick, e.done}) begin
        n_fail++;
        $display("FAIL %s cyc%0d: got fre=%0d busy=%b tick=%b done=%b, want fre=%0d busy=%b tick=%b done=%b",
                 name, i, Fre_word, busy, step_tick, sweep_done, e.fre, e.busy, e.tick, e.done);
      end
      if (step_tick === 1'b1) ticks_seen++;
      if (i == pulse_at) begin
        if (use_stop) stop = 1'b1;
        else          start = 1'b1;
      end
      @(negedge clk_in);
      start = 1'b0; stop = 1'b0;
      i++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk_in);
    n_tests++;
    if ({Fre_word, busy, step_tick, sweep_done} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset: got fre=%0d busy=%b tick=%b done=%b, want all 0", Fre_word, busy, step_tick, sweep_done);
    end
    RST = 1'b0;
    @(negedge clk_in);
    push(32'd0, 0, 0, 0); push(32'd0, 0, 0, 0);
    check_queue("reset_idle", -1, 1'b0);
  endtask

  task automatic test_oneshot;
    do_start(100, 130, 10, 2, 0, 0, 0);
    push_hold(100, 3, 0); push_hold(110, 3, 1); push_hold(120, 3, 1); push_hold(130, 3, 1);
    push(130, 0, 0, 1); push(130, 0, 0, 0); push(130, 0, 0, 0);
    check_queue("oneshot", -1, 1'b0);
  endtask

  task automatic test_clamp;
    do_start(100, 130, 25, 0, 0, 0, 0);
    push_hold(100, 1, 0); push_hold(125, 1, 1); push_hold(130, 1, 1);
    push(130, 0, 0, 1); push(130, 0, 0, 0); push(130, 0, 0, 0);
    check_queue("clamp", -1, 1'b0);
  endtask

  task automatic test_bidir;
    do_start(100, 130, 10, 0, 0, 1, 0);
    push_hold(100, 1, 0);
    push_hold(110, 1, 1); push_hold(120, 1, 1); push_hold(130, 1, 1);
    push_hold(120, 1, 1); push_hold(110, 1, 1); push_hold(100, 1, 1);
    push(100, 0, 0, 1); push(100, 0, 0, 0);
    check_queue("bidir", -1, 1'b0);
    n_tests++;
    if (ticks_seen != 6) begin
      n_fail++;
      $display("FAIL bidir_ticks: got %0d step_tick pulses, want 6", ticks_seen);
    end
  endtask

  task automatic test_loop_stop;
    do_start(100, 130, 10, 2, 1, 0, 0);
    push_hold(100, 3, 0); push_hold(110, 3, 1); push_hold(120, 3, 1); push_hold(130, 3, 1);
    push_hold(100, 3, 1);
    push(110, 1, 1, 0); push(110, 1, 0, 0);
    push(110, 0, 0, 0); push(110, 0, 0, 0); push(110, 0, 0, 0);
    check_queue("loop_stop", 16, 1'b1);
  endtask

  task automatic test_overflow;
    do_start(32'hFFFF_FFEC, 32'hFFFF_FFFF, 16, 0, 0, 0, 0);
    push_hold(32'hFFFF_FFEC, 1, 0); push_hold(32'hFFFF_FFFC, 1, 1); push_hold(32'hFFFF_FFFF, 1, 1);
    push(32'hFFFF_FFFF, 0, 0, 1); push(32'hFFFF_FFFF, 0, 0, 0);
    check_queue("overflow", -1, 1'b0);
  endtask

  task automatic test_degenerate;
    do_start(55, 200, 0, 3, 0, 0, 0);
    push(55, 0, 0, 1); push(55, 0, 0, 0); push(55, 0, 0, 0);
    check_queue("degen_step0", -1, 1'b0);
    do_start(300, 300, 5, 0, 0, 0, 0);
    push(300, 0, 0, 1); push(300, 0, 0, 0);
    check_queue("degen_range", -1, 1'b0);
  endtask

  task automatic test_start_stop_same;
    do_start(900, 950, 10, 0, 0, 0, 1);
    push(300, 0, 0, 0); push(300, 0, 0, 0); push(300, 0, 0, 0);
    check_queue("start_stop_same", -1, 1'b0);
  endtask

  task automatic test_start_while_busy;
    do_start(100, 130, 10, 2, 0, 0, 0);
    // Inputs change mid-sweep; a second start must not disturb the sweep.
    f_start = 7; f_stop = 999; f_step = 1; dwell = 0; mode_loop = 1'b1;
    push_hold(100, 3, 0); push_hold(110, 3, 1); push_hold(120, 3, 1); push_hold(130, 3, 1);
    push(130, 0, 0, 1); push(130, 0, 0, 0);
    check_queue("start_while_busy", 4, 1'b0);
    mode_loop = 1'b0;
  endtask

  task automatic test_rst_mid;
    do_start(100, 130, 10, 2, 0, 0, 0);
    repeat (4) @(negedge clk_in);
    #2 RST = 1'b1;
    #1;
    n_tests++;
    if ({Fre_word, busy, step_tick, sweep_done} !== 35'd0) begin
      n_fail++;
      $display("FAIL rst_mid: got fre=%0d busy=%b tick=%b done=%b, want all 0", Fre_word, busy, step_tick, sweep_done);
    end
    @(negedge clk_in);
    RST = 1'b0;
    @(negedge clk_in);
    push(0, 0, 0, 0); push(0, 0, 0, 0); push(0, 0, 0, 0);
    check_queue("rst_mid_after", -1, 1'b0);
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL timeout: bench exceeded time budget, tests=%0d", n_tests);
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_oneshot();
    test_clamp();
    test_bidir();
    test_loop_stop();
    test_overflow();
    test_degenerate();
    test_start_stop_same();
    test_start_while_busy();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
